// File: rtl/dma_bus_arbiter.sv
// Round-robin arbiter sharing one DMA host-memory port among NREQ requesters.
// Runs one transaction at a time: grant, issue a command, wait for the response or a timeout.
module dma_bus_arbiter #(
  parameter int INW     = 512,
  parameter int ADDRW   = 32,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  input  logic [NREQ*INW-1:0]   req_wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err,
  output logic [INW-1:0]        rdata,
  input  logic                  dma_ready,
  output logic [1:0]            op,
  output logic [ADDRW-1:0]      mem_address,
  output logic [INW-1:0]        dma_wdata,
  input  logic                  rd_valid,
  input  logic [INW-1:0]        dma_rdata,
  input  logic                  tx_done,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    win_q, win_d;
  logic             we_q, we_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [INW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic [INW-1:0]   rdata_q, rdata_d;
  logic [1:0]       op_q, op_d;
  logic [ADDRW-1:0] mem_address_q, mem_address_d;
  logic [INW-1:0]   dma_wdata_q, dma_wdata_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [IW-1:0]    sel;
  int               idx;
  logic             resp;

  // Search starts one past the previous winner so a persistent requester cannot starve others.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    win_d         = win_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    grant_d       = '0;
    done_d        = '0;
    err_d         = '0;
    rdata_d       = rdata_q;
    op_d          = 2'b00;
    mem_address_d = mem_address_q;
    dma_wdata_d   = dma_wdata_q;
    resp          = we_q ? tx_done : rd_valid;
    case (state_q)
      S_IDLE: begin
        if (found && dma_ready) begin
          win_d        = sel;
          last_d       = sel;
          we_d         = req_we[sel];
          addr_d       = req_addr[int'(sel)*ADDRW +: ADDRW];
          wdata_d      = req_wdata[int'(sel)*INW +: INW];
          grant_d[sel] = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        op_d          = we_q ? 2'b10 : 2'b01;
        mem_address_d = addr_q;
        if (we_q) dma_wdata_d = wdata_q;
        cnt_d         = '0;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        // A response in the final counted cycle takes priority over the abort.
        if (resp) begin
          done_d[win_q] = 1'b1;
          if (!we_q) rdata_d = dma_rdata;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d[win_q] = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_q        <= IW'(NREQ - 1);
      win_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      err_q         <= '0;
      rdata_q       <= '0;
      op_q          <= 2'b00;
      mem_address_q <= '0;
      dma_wdata_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      win_q         <= win_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      op_q          <= op_d;
      mem_address_q <= mem_address_d;
      dma_wdata_q   <= dma_wdata_d;
      busy_q        <= busy_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign op          = op_q;
  assign mem_address = mem_address_q;
  assign dma_wdata   = dma_wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: directed scenarios followed by randomized transactions,
// each checked against a transaction-level reference model of the arbitration rules.
module tb_dma_bus_arbiter;

  localparam int INW   = 512;
  localparam int ADDRW = 32;
  localparam int NREQ  = 3;
  localparam int TO    = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ*INW-1:0]   req_wdata;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       err;
  logic [INW-1:0]        rdata;
  logic                  dma_ready;
  logic [1:0]            op;
  logic [ADDRW-1:0]      mem_address;
  logic [INW-1:0]        dma_wdata;
  logic                  rd_valid;
  logic [INW-1:0]        dma_rdata;
  logic                  tx_done;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int             last_m = NREQ - 1;
  logic [INW-1:0] rdata_m = '0;

  dma_bus_arbiter #(.INW(INW), .ADDRW(ADDRW), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .done(done), .err(err), .rdata(rdata),
    .dma_ready(dma_ready), .op(op), .mem_address(mem_address), .dma_wdata(dma_wdata),
    .rd_valid(rd_valid), .dma_rdata(dma_rdata), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [INW-1:0] obs, input logic [INW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INW-1:0] rand_line();
    logic [INW-1:0] v;
    for (int k = 0; k < INW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, INW'(grant), '0);
    chk({tag, "_done"},  INW'(done),  '0);
    chk({tag, "_err"},   INW'(err),   '0);
    chk({tag, "_op"},    INW'(op),    '0);
    chk({tag, "_busy"},  INW'(busy),  '0);
    chk({tag, "_addr"},  INW'(mem_address), '0);
    chk({tag, "_wdata"}, dma_wdata, '0);
    chk({tag, "_rdata"}, rdata, '0);
  endtask

  // One full transaction: optional backpressure, grant, command, response or timeout.
  task automatic do_txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] we, input int delay,
                        input bit respond, input bit stray, input int rdy_delay);
    int              w;
    logic [NREQ-1:0] oh;
    logic            e_we;
    logic [ADDRW-1:0] e_addr;
    logic [INW-1:0]  e_wdata;
    logic [INW-1:0]  resp_data;
    w         = rr_pick(r, last_m);
    oh        = '0;
    oh[w]     = 1'b1;
    e_we      = we[w];
    e_addr    = req_addr[w*ADDRW +: ADDRW];
    e_wdata   = req_wdata[w*INW +: INW];
    resp_data = rand_line();
    req       = r;
    req_we    = we;
    for (int i = 0; i < rdy_delay; i++) begin
      dma_ready = 1'b0;
      tick();
      chk("bp_grant", INW'(grant), '0);
      chk("bp_op", INW'(op), '0);
    end
    dma_ready = 1'b1;
    tick();
    chk("grant", INW'(grant), INW'(oh));
    chk("busy", INW'(busy), INW'(1'b1));
    last_m    = w;
    req       = '0;
    req_we    = ~we;
    req_addr  = {$urandom, $urandom, $urandom};
    req_wdata = {rand_line(), rand_line(), rand_line()};
    tick();
    chk("op", INW'(op), e_we ? INW'(2'b10) : INW'(2'b01));
    chk("mem_address", INW'(mem_address), INW'(e_addr));
    if (e_we) chk("dma_wdata", dma_wdata, e_wdata);
    chk("grant_pulse", INW'(grant), '0);
    for (int j = 0; j < TO; j++) begin
      bit hit;
      hit = respond && (j == delay);
      if (e_we) begin
        tx_done   = hit;
        rd_valid  = stray;
        dma_rdata = rand_line();
      end else begin
        rd_valid  = hit || stray;
        tx_done   = stray;
        dma_rdata = (hit || !stray) ? resp_data : rand_line();
        if (stray && !hit) rd_valid = 1'b0;
      end
      tick();
      rd_valid = 1'b0;
      tx_done  = 1'b0;
      if (j > 0) chk("op_back_to_nop", INW'(op), '0);
      if (hit) begin
        if (!e_we) rdata_m = resp_data;
        chk("done", INW'(done), INW'(oh));
        chk("no_err", INW'(err), '0);
        break;
      end else if (j == TO - 1) begin
        chk("err", INW'(err), INW'(oh));
        chk("no_done", INW'(done), '0);
      end else begin
        chk("waiting", INW'({done, err}), '0);
      end
    end
    chk("idle_busy", INW'(busy), '0);
    chk("rdata", rdata, rdata_m);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    dma_ready = 1'b1; rd_valid = 1'b0; dma_rdata = '0; tx_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Single read, response five cycles after the command
    req_addr[0*ADDRW +: ADDRW] = 32'h0000_1000;
    do_txn(3'b001, 3'b000, 5, 1'b1, 1'b0, 0);

    // Write with stray rd_valid
    req_addr[2*ADDRW +: ADDRW] = 32'h0000_2000;
    req_wdata[2*INW +: INW] = rand_line();
    do_txn(3'b100, 3'b100, 3, 1'b1, 1'b1, 0);

    // Round-robin with immediate responses
    for (int n = 0; n < 4; n++) do_txn(3'b111, 3'b000, 0, 1'b1, 1'b0, 0);
    for (int n = 0; n < 3; n++) do_txn(3'b101, 3'b101, 0, 1'b1, 1'b0, 0);

    // Timeout, then a response landing on the last counted cycle
    do_txn(3'b010, 3'b000, 0, 1'b0, 1'b0, 0);
    tick();
    chk("busy_after_err", INW'(busy), '0);
    do_txn(3'b010, 3'b000, TO - 1, 1'b1, 1'b0, 0);

    // Reset in the middle of a read
    req = 3'b001; req_we = 3'b000;
    tick();
    req = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_m  = NREQ - 1;
    rdata_m = '0;
    chk_reset_outputs("midwait_reset");
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      chk("post_reset_quiet", INW'({done, err, grant}), '0);
    end
    do_txn(3'b111, 3'b000, 1, 1'b1, 1'b0, 0);

    // Backpressure for ten cycles
    do_txn(3'b010, 3'b000, 2, 1'b1, 1'b0, 10);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [NREQ-1:0] r;
      r = NREQ'($urandom_range(1, 7));
      req_addr  = {$urandom, $urandom, $urandom};
      req_wdata = {rand_line(), rand_line(), rand_line()};
      do_txn(r, NREQ'($urandom_range(0, 7)), $urandom_range(0, TO - 1),
             ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
